// File: rtl/dense_mac_sequencer.sv
// Serial dense-layer evaluator: one shared MAC walks IN_SIZE inputs per neuron,
// emits each neuron result on a strobe and reports the argmax class at the end.
module dense_mac_sequencer #(
   parameter int IN_SIZE  = 32,
   parameter int OUT_SIZE = 3,
   parameter int X_W      = 40,
   parameter int W_W      = 8,
   parameter int B_W      = 16,
   parameter int ACC_W    = 48
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   output logic                                 busy,
   output logic [$clog2(IN_SIZE)-1:0]           x_addr,
   input  logic signed [X_W-1:0]                x_data,
   output logic [$clog2(IN_SIZE*OUT_SIZE)-1:0]  w_addr,
   input  logic signed [W_W-1:0]                w_data,
   output logic [$clog2(OUT_SIZE)-1:0]          b_addr,
   input  logic signed [B_W-1:0]                b_data,
   output logic                                 out_valid,
   output logic [$clog2(OUT_SIZE)-1:0]          out_idx,
   output logic signed [ACC_W-1:0]              out_data,
   output logic                                 done,
   output logic [$clog2(OUT_SIZE)-1:0]          class_idx
);

   localparam int KW  = $clog2(IN_SIZE);
   localparam int NW  = $clog2(OUT_SIZE);
   localparam int WAW = $clog2(IN_SIZE*OUT_SIZE);

   typedef enum logic [2:0] {
      ST_IDLE, ST_RUN, ST_DRAIN, ST_BIAS, ST_EMIT, ST_DONE
   } state_e;

   state_e                   state_q, state_d;
   logic [NW-1:0]            n_q, n_d;
   logic [KW-1:0]            k_q, k_d;
   logic [WAW-1:0]           w_addr_q, w_addr_d;
   logic                     pend_q, pend_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [ACC_W-1:0]  best_q, best_d;
   logic [NW-1:0]            best_idx_q, best_idx_d;
   logic signed [ACC_W-1:0]  out_data_q, out_data_d;
   logic [NW-1:0]            out_idx_q, out_idx_d;
   logic                     out_valid_q, out_valid_d;
   logic                     done_q, done_d;
   logic                     busy_q, busy_d;
   logic [NW-1:0]            class_idx_q, class_idx_d;

   logic signed [ACC_W-1:0]  prod;
   logic signed [ACC_W-1:0]  bias_ext;
   logic                     take_new;

   // Both operands are signed, so the size casts sign-extend before the multiply.
   assign prod     = ACC_W'(x_data) * ACC_W'(w_data);
   assign bias_ext = ACC_W'(b_data);
   assign take_new = (n_q == '0) || (out_data_q > best_q);

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves a variable unassigned (no latches).
      state_d     = state_q;
      n_d         = n_q;
      k_d         = k_q;
      w_addr_d    = w_addr_q;
      pend_d      = pend_q;
      acc_d       = acc_q;
      best_d      = best_q;
      best_idx_d  = best_idx_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      busy_d      = busy_q;
      class_idx_d = class_idx_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               n_d        = '0;
               k_d        = '0;
               w_addr_d   = '0;
               pend_d     = 1'b0;
               acc_d      = '0;
               best_d     = '0;
               best_idx_d = '0;
               busy_d     = 1'b1;
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            // pend_q marks that an address went out last cycle, so its data is here now.
            if (pend_q) acc_d = acc_q + prod;
            pend_d   = 1'b1;
            k_d      = k_q + KW'(1);
            w_addr_d = w_addr_q + WAW'(1);
            if (k_q == KW'(IN_SIZE-1)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            acc_d   = acc_q + prod;
            pend_d  = 1'b0;
            state_d = ST_BIAS;
         end
         ST_BIAS: begin
            out_data_d  = acc_q + bias_ext;
            out_idx_d   = n_q;
            out_valid_d = 1'b1;
            state_d     = ST_EMIT;
         end
         ST_EMIT: begin
            if (take_new) begin
               best_d     = out_data_q;
               best_idx_d = n_q;
            end
            acc_d = '0;
            k_d   = '0;
            if (n_q == NW'(OUT_SIZE-1)) begin
               done_d      = 1'b1;
               class_idx_d = take_new ? n_q : best_idx_q;
               state_d     = ST_DONE;
            end else begin
               n_d     = n_q + NW'(1);
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         n_q         <= '0;
         k_q         <= '0;
         w_addr_q    <= '0;
         pend_q      <= 1'b0;
         acc_q       <= '0;
         best_q      <= '0;
         best_idx_q  <= '0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         class_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         k_q         <= k_d;
         w_addr_q    <= w_addr_d;
         pend_q      <= pend_d;
         acc_q       <= acc_d;
         best_q      <= best_d;
         best_idx_q  <= best_idx_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         class_idx_q <= class_idx_d;
      end
   end

   assign busy      = busy_q;
   assign x_addr    = k_q;
   assign w_addr    = w_addr_q;
   assign b_addr    = n_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_data  = out_data_q;
   assign done      = done_q;
   assign class_idx = class_idx_q;

endmodule

// File: tb/tb_dense_mac_sequencer.sv
// Directed bench for dense_mac_sequencer: reference-model scoreboard plus
// cycle-exact checks of strobes, busy and ROM addresses.
module tb_dense_mac_sequencer;

   localparam int IN_SIZE  = 32;
   localparam int OUT_SIZE = 3;
   localparam int X_W      = 40;
   localparam int W_W      = 8;
   localparam int B_W      = 16;
   localparam int ACC_W    = 48;
   localparam int PER      = IN_SIZE + 3;
   localparam int DONE_CYC = OUT_SIZE*PER + 1;

   typedef struct {
      int                      idx;
      logic signed [ACC_W-1:0] data;
   } exp_t;

   logic                           clk = 1'b0;
   logic                           rst = 1'b1;
   logic                           start = 1'b0;
   logic                           busy;
   logic [4:0]                     x_addr;
   logic signed [X_W-1:0]          x_data;
   logic [6:0]                     w_addr;
   logic signed [W_W-1:0]          w_data;
   logic [1:0]                     b_addr;
   logic signed [B_W-1:0]          b_data;
   logic                           out_valid;
   logic [1:0]                     out_idx;
   logic signed [ACC_W-1:0]        out_data;
   logic                           done;
   logic [1:0]                     class_idx;

   logic signed [X_W-1:0]          xmem [32];
   logic signed [W_W-1:0]          wmem [128];
   logic signed [B_W-1:0]          bmem [4];

   exp_t sb[$];
   int   exp_class = 0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   dense_mac_sequencer #(
      .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .X_W(X_W),
      .W_W(W_W), .B_W(B_W), .ACC_W(ACC_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .x_addr(x_addr), .x_data(x_data),
      .w_addr(w_addr), .w_data(w_data),
      .b_addr(b_addr), .b_data(b_data),
      .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
      .done(done), .class_idx(class_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous ROM/buffer models with one cycle of read latency.
   always @(posedge clk) begin
      x_data <= xmem[x_addr];
      w_data <= wmem[w_addr];
      b_data <= bmem[b_addr];
   end

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic load(input int test);
      for (int k = 0; k < 32; k++) begin
         case (test)
            1:       xmem[k] = X_W'((k % 4) + 1);
            3:       xmem[k] = {1'b0, {(X_W-1){1'b1}}};
            default: xmem[k] = X_W'(1);
         endcase
      end
      for (int a = 0; a < 128; a++) begin
         case (test)
            0:       wmem[a] = (a < 32) ? 8'sd1 : (a < 64) ? 8'sd2 : -8'sd1;
            1:       wmem[a] = 8'sd3;
            2:       wmem[a] = 8'sd0;
            default: wmem[a] = (a < 32) ? 8'sd127 : (a < 64) ? 8'sd1 : -8'sd1;
         endcase
      end
      for (int n = 0; n < 4; n++) begin
         case (test)
            1:       bmem[n] = (n == 1) ? 16'sd10 : (n == 2) ? -16'sd10 : 16'sd0;
            2:       bmem[n] = -16'sd5;
            default: bmem[n] = 16'sd0;
         endcase
      end
   endtask

   task automatic push_model();
      longint                  acc;
      logic signed [ACC_W-1:0] r;
      logic signed [ACC_W-1:0] best;
      int                      bi;
      exp_t                    e;
      best = '0;
      bi   = 0;
      for (int n = 0; n < OUT_SIZE; n++) begin
         acc = 0;
         for (int k = 0; k < IN_SIZE; k++)
            acc += longint'(xmem[k]) * longint'(wmem[n*IN_SIZE + k]);
         acc += longint'(bmem[n]);
         r = acc[ACC_W-1:0];
         e.idx  = n;
         e.data = r;
         sb.push_back(e);
         if (n == 0 || r > best) begin
            best = r;
            bi   = n;
         end
      end
      exp_class = bi;
   endtask

   // Starts one evaluation at the current negedge and checks every cycle up to
   // DONE_CYC+1. rst_cyc>0 asserts reset in that cycle; spur_* pulse start while busy.
   task automatic run_eval(input int rst_cyc, input int spur_a, input int spur_b);
      int   nv;
      int   nd;
      bit   dead;
      exp_t e;
      push_model();
      nv    = 0;
      nd    = 0;
      start = 1'b1;
      for (int r = 1; r <= DONE_CYC + 1; r++) begin
         @(negedge clk);
         dead = (rst_cyc > 0) && (r > rst_cyc);
         check("busy", busy, (!dead && r <= DONE_CYC));
         check("out_valid", out_valid, (!dead && r % PER == 0 && r <= OUT_SIZE*PER));
         check("done", done, (!dead && r == DONE_CYC));
         if (!dead && r <= OUT_SIZE*PER) begin
            if ((r-1) % PER < IN_SIZE) begin
               check("x_addr", x_addr, (r-1) % PER);
               check("w_addr", w_addr, ((r-1) / PER)*IN_SIZE + (r-1) % PER);
            end else if ((r-1) % PER == IN_SIZE) begin
               check("b_addr", b_addr, (r-1) / PER);
            end
         end
         if (out_valid) begin
            nv++;
            check("sb_nonempty", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("out_data", out_data, e.data);
               check("out_idx", out_idx, e.idx);
            end
         end
         if (done) begin
            nd++;
            check("class_idx", class_idx, exp_class);
         end
         if (rst_cyc > 0 && r == rst_cyc + 1) begin
            check("rst_out_data", out_data, 0);
            check("rst_out_idx", out_idx, 0);
            check("rst_class_idx", class_idx, 0);
            check("sb_left", sb.size(), OUT_SIZE - rst_cyc / PER);
            sb.delete();
         end
         if (!dead && r == DONE_CYC + 1)
            check("class_idx_hold", class_idx, exp_class);
         rst   = (r == rst_cyc);
         start = (r == spur_a) || (r == spur_b);
      end
      if (rst_cyc == 0) begin
         check("n_valid", nv, OUT_SIZE);
         check("n_done", nd, 1);
         check("sb_drained", sb.size(), 0);
      end else begin
         check("n_done_after_rst", nd, 0);
      end
   endtask

   initial begin
      load(0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_done", done, 0);
      check("reset_out_idx", out_idx, 0);
      check("reset_out_data", out_data, 0);
      check("reset_class_idx", class_idx, 0);
      check("reset_x_addr", x_addr, 0);
      check("reset_w_addr", w_addr, 0);
      check("reset_b_addr", b_addr, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_busy", busy, 0);

      load(0);
      run_eval(0, 0, 0);
      load(1);
      run_eval(0, 0, 0);
      load(2);
      run_eval(0, 0, 0);
      load(3);
      run_eval(0, 0, 0);

      // start pulses while busy are ignored; the back-to-back call starts at cycle 107.
      load(0);
      run_eval(0, 20, 60);
      run_eval(0, 0, 0);

      run_eval(50, 0, 0);
      repeat (3) @(negedge clk);
      check("post_rst_idle_busy", busy, 0);
      run_eval(0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dense_mac_sequencer.md
# dense_mac_sequencer

Sequences the final dense layer of the keyword classifier (32 inputs, 3 classes) over a single shared multiply-accumulate. It walks the input buffer and the weight/bias ROMs, accumulates each neuron serially, and emits one result per neuron on a valid strobe. After the last neuron it reports the winning class index. It replaces the fully parallel layer-4 datapath to save DSPs, and plugs between the layer-3 output buffer and the decision logic.

## Interface
- IN_SIZE, 32: inputs per neuron
- OUT_SIZE, 3: neurons (classes)
- X_W, 40: input element width, signed
- W_W, 8: weight width, signed
- B_W, 16: bias width, signed
- ACC_W, 48: accumulator and output width, signed

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one layer evaluation; sampled only in IDLE
- busy  out  1  high from first RUN cycle through the DONE cycle
- x_addr  out  $clog2(IN_SIZE)  input buffer read address
- x_data  in  X_W  input buffer data, 1-cycle read latency
- w_addr  out  $clog2(IN_SIZE*OUT_SIZE)  weight ROM address = n*IN_SIZE+k
- w_data  in  W_W  weight data, 1-cycle read latency
- b_addr  out  $clog2(OUT_SIZE)  bias ROM address = n
- b_data  in  B_W  bias data, 1-cycle read latency
- out_valid  out  1  one-cycle pulse, out_data/out_idx valid
- out_idx  out  $clog2(OUT_SIZE)  neuron index of out_data
- out_data  out  ACC_W  neuron result, sum of x*w plus bias
- done  out  1  one-cycle pulse at end of evaluation
- class_idx  out  $clog2(OUT_SIZE)  argmax of the neuron results, held until next done

## Operation
- FSM states: IDLE, RUN, DRAIN, BIAS, EMIT, DONE.
- IDLE: if start, then clear n, k, acc, best value and best index; go to RUN.
- RUN: drive x_addr=k and w_addr=n*IN_SIZE+k. The product for the address issued in the previous cycle is accumulated. k increments each cycle. After issuing k=IN_SIZE-1, go to DRAIN.
- DRAIN: accumulate the last product and drive b_addr=n. Go to BIAS.
- BIAS: register out_data <= acc + sign-extended b_data and set out_idx <= n. Go to EMIT.
- EMIT: out_valid=1. Update argmax: if n==0 or out_data > best, then best <= out_data and best index <= n. Clear acc and k. If n==OUT_SIZE-1, go to DONE; else increment n and go to RUN.
- DONE: done=1 and class_idx <= final best index. Go to IDLE.
- Arithmetic:
  - product is a signed X_W × W_W product, 48 bits;
  - accumulation wraps modulo 2^ACC_W, with no saturation;
  - bias is sign-extended to ACC_W before the add;
  - comparison is signed.
- Ties resolve to the lowest index (strict greater-than).
- start while busy is ignored. start held high in IDLE after DONE begins a new evaluation.
- Addresses are don't-care outside the states that drive them; the bench checks them only in RUN/DRAIN.

## Timing
- Reset values: busy=0, out_valid=0, done=0, out_idx=0, out_data=0, class_idx=0, x_addr=0, w_addr=0, b_addr=0; state is IDLE.
- start sampled high at edge 0 gives RUN in cycles 1..IN_SIZE, DRAIN in cycle IN_SIZE+1, BIAS in IN_SIZE+2, EMIT in IN_SIZE+3.
- Per neuron: IN_SIZE+3 cycles (35 with defaults). Neuron n out_valid occurs in cycle (n+1)*35.
- done occurs in cycle OUT_SIZE*35+1 = 106. busy is high in cycles 1..106 and low from 107.
- Minimum start-to-start spacing is 107 cycles.
- rst takes priority over everything in any state. The next cycle is IDLE with all outputs at reset values. A partial evaluation produces no further out_valid or done.
- out_data/out_idx hold their last value between pulses.

## Test plan
- Basic: all x=1; weights 1, 2, -1 for neurons 0, 1, 2; biases 0.
  - out_data 32, 64, -32 on out_valid at cycles 35, 70, 105;
  - done at 106 with class_idx=1;
  - busy low at 107.
- Pattern: x = 1,2,3,4 repeated; all weights 3; biases 0, 10, -10.
  - outputs 240, 250, 230;
  - class_idx=1;
  - check w_addr = n*32+k every RUN cycle.
- Ties and negatives: all weights 0, biases -5, -5, -5.
  - outputs -5, -5, -5;
  - class_idx=0.
- Wrap: all x = 2^39-1, weights 127 for neuron 0, biases 0.
  - out_data[0] = low 48 bits of 32*127*(2^39-1), interpreted signed;
  - no saturation.
- Handshake: pulse start again at cycle 20 and cycle 60.
  - ignored; exactly 3 out_valid and 1 done are produced.
  - start at cycle 107 begins a second evaluation with identical results.
- Reset mid-op: assert rst in cycle 50.
  - from cycle 51: busy=0, out_valid=0, done=0;
  - no done appears;
  - a following start yields the correct basic-test results.
